// File: rtl/aes_pkg.sv
// Shared definitions for the AES key expander: state type, round count and
// the GF(2^8) doubling used to step the round constant.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int aes_nr(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-box lookups applied bytewise to a 32-bit word.
// Purely combinational; the table is packed with byte 0x00 in the top bits.
module aes_sbox_word (
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset 8*(255-x), and 255-x is simply ~x.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    assign sub_word = {sbox(word[31:24]), sbox(word[23:16]),
                       sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key expander: generates one schedule word per cycle and
// streams 128-bit round keys over a valid/ready handshake.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [32*NK-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_index,
    output logic             done
);

    localparam int         NR        = aes_nr(NK);
    localparam int         NW        = 4 * (NR + 1);
    localparam logic [5:0] LAST_WORD = 6'(NW - 1);
    localparam logic [2:0] LAST_KPOS = 3'(NK - 1);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_key_expand: NK must be 4, 6 or 8");
        end
    endgenerate

    state_t      state;
    state_t      state_next;
    logic [5:0]  word_cnt;
    logic [2:0]  kpos;
    logic [7:0]  rcon;
    logic [31:0] window [NK];
    logic [31:0] asm_buf [3];

    logic [31:0] prev_word;
    logic [31:0] key_word;
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;
    logic [31:0] xor_term;
    logic [31:0] new_word;
    logic        in_key;
    logic        completes;
    logic        stall;
    logic        advance;
    logic        handshake;

    assign handshake = rk_valid && rk_ready;
    assign in_key    = (word_cnt < 6'(NK));
    assign completes = (word_cnt[1:0] == 2'd3);
    assign stall     = completes && rk_valid && !rk_ready;
    assign advance   = (state == RUN) && !stall;
    assign prev_word = window[NK-1];
    assign busy      = (state != IDLE);

    always_comb begin
        key_word = '0;
        for (int j = 0; j < NK; j++) begin
            if (word_cnt == 6'(j)) key_word = window[j];
        end
    end

    // One S-box instance serves both RotWord+SubWord and the AES-256 mid-key SubWord.
    assign sbox_in = (kpos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sbox_word u_sbox (
        .word     (sbox_in),
        .sub_word (sbox_out)
    );

    always_comb begin
        xor_term = prev_word;
        if (kpos == 3'd0) begin
            xor_term = sbox_out ^ {rcon, 24'h0};
        end else if (NK == 8 && kpos == 3'd4) begin
            xor_term = sbox_out;
        end
        new_word = in_key ? key_word : (window[0] ^ xor_term);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (advance && word_cnt == LAST_WORD) state_next = DRAIN;
            DRAIN:   if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The window only shifts once key words are exhausted, so it always holds w[i-NK..i-1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            kpos     <= '0;
            rcon     <= RCON_INIT;
            for (int j = 0; j < NK; j++) window[j] <= '0;
            for (int j = 0; j < 3; j++) asm_buf[j] <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                word_cnt <= '0;
                kpos     <= '0;
                rcon     <= RCON_INIT;
                for (int j = 0; j < NK; j++) window[j] <= key_in[32*(NK-j)-1 -: 32];
            end
        end else if (advance) begin
            word_cnt <= word_cnt + 6'd1;
            kpos     <= (kpos == LAST_KPOS) ? 3'd0 : kpos + 3'd1;
            if (!in_key) begin
                for (int j = 0; j < NK - 1; j++) window[j] <= window[j+1];
                window[NK-1] <= new_word;
                if (kpos == 3'd0) rcon <= xtime(rcon);
            end
            if (!completes) asm_buf[word_cnt[1:0]] <= new_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == DRAIN) && handshake;
            if (advance && completes) begin
                rk_valid <= 1'b1;
                rk_data  <= {asm_buf[0], asm_buf[1], asm_buf[2], new_word};
                rk_index <= word_cnt[5:2];
            end else if (handshake) begin
                rk_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: three instances (NK = 4, 6, 8) checked
// every cycle against a key-level schedule model driven by FIPS-197 vectors.
module tb_aes_key_expand;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] KEY_X  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   start_v;
    logic [2:0]   ready_v;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;

    wire          busy4, valid4, done4, busy6, valid6, done6, busy8, valid8, done8;
    wire [127:0]  data4, data6, data8;
    wire [3:0]    idx4, idx6, idx8;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [3][15];
    bit           busy_m [3];
    bit           val_m  [3];
    bit           done_m [3];
    int           idx_m  [3];
    int           e_m    [3];
    int           next_r [3];
    int           due_m  [3];

    always #5 clk = ~clk;

    aes_key_expand #(.NK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .key_in(key4), .busy(busy4),
        .rk_valid(valid4), .rk_ready(ready_v[0]), .rk_data(data4), .rk_index(idx4), .done(done4)
    );

    aes_key_expand #(.NK(6)) dut6 (
        .clk(clk), .rst(rst), .start(start_v[1]), .key_in(key6), .busy(busy6),
        .rk_valid(valid6), .rk_ready(ready_v[1]), .rk_data(data6), .rk_index(idx6), .done(done6)
    );

    aes_key_expand #(.NK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .key_in(key8), .busy(busy8),
        .rk_valid(valid8), .rk_ready(ready_v[2]), .rk_data(data8), .rk_index(idx8), .done(done8)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input int d, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = 4 + 2 * d;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word_m(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) exp_rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Key-level timing model: key r can load 4 edges after the previous load,
    // but not before the previous key has been (or is being) accepted.
    always @(negedge clk) begin : compare
        logic         v   [3];
        logic         b   [3];
        logic         dn  [3];
        logic [3:0]   ix  [3];
        logic [127:0] dat [3];
        logic [255:0] kk  [3];
        bit           hs;
        int           nk;
        int           nr;
        v[0] = valid4; b[0] = busy4; dn[0] = done4; ix[0] = idx4; dat[0] = data4; kk[0] = {key4, 128'h0};
        v[1] = valid6; b[1] = busy6; dn[1] = done6; ix[1] = idx6; dat[1] = data6; kk[1] = {key6, 64'h0};
        v[2] = valid8; b[2] = busy8; dn[2] = done8; ix[2] = idx8; dat[2] = data8; kk[2] = key8;
        for (int d = 0; d < 3; d++) begin
            nk = 4 + 2 * d;
            nr = nk + 6;
            if (rst) begin
                checkOutput($sformatf("reset_ctrl_nk%0d", nk), 128'({v[d], b[d], dn[d], ix[d]}), 128'h0);
                checkOutput($sformatf("reset_data_nk%0d", nk), dat[d], 128'h0);
                busy_m[d] = 1'b0;
                val_m[d]  = 1'b0;
                done_m[d] = 1'b0;
            end else begin
                checkOutput($sformatf("busy_nk%0d", nk), 128'(b[d]), 128'(busy_m[d]));
                checkOutput($sformatf("valid_nk%0d", nk), 128'(v[d]), 128'(val_m[d]));
                checkOutput($sformatf("done_nk%0d", nk), 128'(dn[d]), 128'(done_m[d]));
                if (val_m[d]) begin
                    checkOutput($sformatf("index_nk%0d", nk), 128'(ix[d]), 128'(idx_m[d]));
                    checkOutput($sformatf("rk%0d_nk%0d", idx_m[d], nk), dat[d], exp_rk[d][idx_m[d]]);
                end
                hs        = val_m[d] && ready_v[d];
                done_m[d] = hs && (idx_m[d] == nr);
                if (busy_m[d]) begin
                    if (done_m[d]) begin
                        busy_m[d] = 1'b0;
                        val_m[d]  = 1'b0;
                    end else begin
                        e_m[d]++;
                        if (next_r[d] <= nr && e_m[d] >= due_m[d] && (!val_m[d] || hs)) begin
                            val_m[d] = 1'b1;
                            idx_m[d] = next_r[d];
                            next_r[d]++;
                            due_m[d] = e_m[d] + 4;
                        end else if (hs) begin
                            val_m[d] = 1'b0;
                        end
                    end
                end else if (start_v[d]) begin
                    busy_m[d] = 1'b1;
                    e_m[d]    = 0;
                    next_r[d] = 0;
                    due_m[d]  = 4;
                    expand(d, kk[d]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] which, input logic [127:0] k4,
                                 input logic [191:0] k6, input logic [255:0] k8);
        @(posedge clk); #1;
        key4    = k4;
        key6    = k6;
        key8    = k8;
        start_v = which;
        @(posedge clk); #1;
        start_v = 3'b000;
    endtask

    task automatic waitKey(input int r, input int budget, output logic [127:0] data);
        bit found;
        found = 1'b0;
        data  = '0;
        for (int n = 0; n < budget && !found; n++) begin
            @(posedge clk); #1;
            if (valid4 && idx4 == 4'(r)) begin
                found = 1'b1;
                data  = data4;
            end
        end
        checkOutput($sformatf("wait_rk%0d", r), 128'(found), 128'd1);
    endtask

    task automatic waitDone(input int budget);
        bit found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(posedge clk); #1;
            if (done4) found = 1'b1;
        end
        checkOutput("wait_done", 128'(found), 128'd1);
    endtask

    initial begin : watchdog
        #100000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        int           t_last [3];
        int           t_done [3];
        logic [127:0] last_rk [3];
        logic [127:0] cap;
        bit           held;
        int           low_left;

        rst     = 1'b1;
        start_v = 3'b000;
        ready_v = 3'b111;
        key4    = '0;
        key6    = '0;
        key8    = '0;

        buildSbox();
        checkOutput("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
        checkOutput("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
        expand(0, {KEY_A1, 128'h0});
        checkOutput("model_a1_rk1", exp_rk[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("model_a1_rk10", exp_rk[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        expand(1, {KEY_A2, 64'h0});
        checkOutput("model_a2_rk12", exp_rk[1][12], 128'he98ba06f448c773c8ecc720401002202);
        expand(2, KEY_A3);
        checkOutput("model_a3_rk14", exp_rk[2][14], 128'hfe4890d1e6188d0b046df344706c631e);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state_ctrl", 128'({busy4, valid4, done4, idx4}), 128'h0);
        checkOutput("reset_state_data", data4, 128'h0);
        rst = 1'b0;

        $display("[TB] all three key sizes with rk_ready high");
        for (int d = 0; d < 3; d++) begin
            t_last[d]  = -1;
            t_done[d]  = -1;
            last_rk[d] = '0;
        end
        applyStimulus(3'b111, KEY_A1, KEY_A2, KEY_A3);
        for (int n = 1; n <= 120; n++) begin
            @(posedge clk); #1;
            if (n == 4) begin
                checkOutput("a1_rk0_valid", 128'(valid4), 128'd1);
                checkOutput("a1_rk0", data4, KEY_A1);
            end
            if (n == 8) checkOutput("a1_rk1", data4, 128'ha0fafe1788542cb123a339392a6c7605);
            if (t_last[0] < 0 && valid4 && idx4 == 4'd10) begin t_last[0] = n; last_rk[0] = data4; end
            if (t_last[1] < 0 && valid6 && idx6 == 4'd12) begin t_last[1] = n; last_rk[1] = data6; end
            if (t_last[2] < 0 && valid8 && idx8 == 4'd14) begin t_last[2] = n; last_rk[2] = data8; end
            if (t_done[0] < 0 && done4) t_done[0] = n;
            if (t_done[1] < 0 && done6) t_done[1] = n;
            if (t_done[2] < 0 && done8) t_done[2] = n;
            if (t_done[0] > 0 && t_done[1] > 0 && t_done[2] > 0) break;
        end
        checkOutput("a1_rk10_edge", 128'(t_last[0]), 128'd44);
        checkOutput("a1_done_edge", 128'(t_done[0]), 128'd45);
        checkOutput("a2_rk12_edge", 128'(t_last[1]), 128'd52);
        checkOutput("a2_done_edge", 128'(t_done[1]), 128'd53);
        checkOutput("a3_rk14_edge", 128'(t_last[2]), 128'd60);
        checkOutput("a3_done_edge", 128'(t_done[2]), 128'd61);
        checkOutput("a1_rk10", last_rk[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("a2_rk12", last_rk[1], 128'he98ba06f448c773c8ecc720401002202);
        checkOutput("a3_rk14", last_rk[2], 128'hfe4890d1e6188d0b046df344706c631e);
        repeat (3) @(posedge clk);

        $display("[TB] back-pressure on NK=4");
        held     = 1'b0;
        low_left = 0;
        cap      = '0;
        applyStimulus(3'b001, KEY_A1, KEY_A2, KEY_A3);
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (done4) begin
                cap = 128'd1;
                break;
            end
            if (!held && valid4 && idx4 == 4'd3) begin
                held     = 1'b1;
                low_left = 7;
            end
            if (low_left > 0) begin
                ready_v[0] = 1'b0;
                low_left--;
            end else begin
                ready_v[0] = ($urandom_range(0, 3) != 0);
            end
        end
        ready_v[0] = 1'b1;
        checkOutput("bp_done_seen", cap, 128'd1);
        checkOutput("bp_long_stall_applied", 128'(held), 128'd1);
        repeat (3) @(posedge clk);

        $display("[TB] start pulse while busy is ignored");
        applyStimulus(3'b001, KEY_A1, KEY_A2, KEY_A3);
        repeat (6) @(posedge clk);
        applyStimulus(3'b001, KEY_X, KEY_A2, KEY_A3);
        waitKey(10, 80, cap);
        checkOutput("ignored_start_rk10", cap, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        waitDone(10);
        repeat (3) @(posedge clk);

        $display("[TB] reset mid-expansion then restart");
        applyStimulus(3'b001, KEY_A1, KEY_A2, KEY_A3);
        waitKey(5, 60, cap);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_ctrl", 128'({busy4, valid4, done4, idx4}), 128'h0);
        checkOutput("mid_reset_data", data4, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        applyStimulus(3'b001, KEY_A1, KEY_A2, KEY_A3);
        waitKey(0, 20, cap);
        checkOutput("restart_rk0", cap, KEY_A1);
        waitKey(10, 80, cap);
        checkOutput("restart_rk10", cap, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        waitDone(10);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
